// File: rtl/rover_pwm_bank.sv
// Multi-channel PWM bank with a shared period counter, wrap-committed duty
// shadows and a command watchdog that drives every output low on timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | counter parked at 0, period/duty tracked live, outputs low
// ST_RUN   | counter running 0..period_q, outputs follow active duties
// ST_FAULT | watchdog expired; outputs low until a write with enable low
module rover_pwm_bank #(
    parameter int NUM_CH     = 6,
    parameter int CNT_W      = 16,
    parameter int WD_W       = 24,
    parameter int WD_TIMEOUT = 5_000_000,
    localparam int CH_W      = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic              wr_en_i,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic [CNT_W-1:0]  wr_duty_i,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              sync_o,
    output logic              wd_fault_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // One extra bit so NUM_CH itself (e.g. 16 with a 4-bit index) is representable.
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WD_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q;
    logic [WD_W-1:0]  wd_cnt;
    logic [CNT_W-1:0] shadow [NUM_CH];
    logic [CNT_W-1:0] active [NUM_CH];
    logic             valid_wr;
    logic             timeout;
    logic             wrap;

    assign valid_wr   = wr_en_i && ({1'b0, wr_ch_i} < NUM_CH_V);
    // A valid write in the expiry cycle rescues the watchdog.
    assign timeout    = (state != ST_FAULT) && !valid_wr && (wd_cnt >= WD_LAST);
    assign wrap       = (state == ST_RUN) && (cnt == period_q);
    assign wd_fault_o = (state == ST_FAULT);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; watchdog expiry outranks the enable input.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (timeout)       state_nxt = ST_FAULT;
                else if (enable_i) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (timeout)        state_nxt = ST_FAULT;
                else if (!enable_i) state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (valid_wr && !enable_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Watchdog: counts cycles since the last valid write, parked at 0 in fault.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if ((state == ST_FAULT) || valid_wr || timeout) begin
            wd_cnt <= '0;
        end else if (wd_cnt != {WD_W{1'b1}}) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Shared period counter; period_i is only sampled while idle or at wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            period_q <= '0;
            sync_o   <= 1'b0;
        end else if (timeout || (state != ST_RUN)) begin
            cnt    <= '0;
            sync_o <= 1'b0;
            if (!timeout && (state == ST_IDLE)) begin
                period_q <= period_i;
            end
        end else if (wrap) begin
            cnt      <= '0;
            period_q <= period_i;
            sync_o   <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            sync_o <= 1'b0;
        end
    end

    // Per-channel duty path: host writes land in shadow, active only changes
    // while idle or at wrap so a period never sees a mid-cycle duty change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_o <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else if (timeout) begin
            pwm_o <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((state == ST_IDLE) || wrap) begin
                    active[i] <= shadow[i];
                end
                pwm_o[i] <= (state == ST_RUN) && (cnt < active[i]);
                if (valid_wr && (wr_ch_i == CH_W'(i))) begin
                    shadow[i] <= wr_duty_i;
                end
            end
        end
    end

endmodule
